// File: rtl/i2cm_arb_pkg.sv
// Shared types and cfg field layout for the i2cm multi-channel trigger arbiter.
package i2cm_arb_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} arb_state_e;

    localparam int CFG_W        = 28;
    localparam int CFG_ADDR_LSB = 0;
    localparam int CFG_DEV_LSB  = 8;
    localparam int CFG_NUM_LSB  = 16;
    localparam int CFG_SEQ_BIT  = 24;
    localparam int CFG_STB_BIT  = 25;
    localparam int CFG_TYPE_BIT = 26;
    localparam int CFG_NACK_BIT = 27;
endpackage

// File: rtl/i2cm_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr_i, wrapping N-1 -> 0.
module i2cm_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         gnt_vld_o,
    output logic [W-1:0] gnt_idx_o
);
    logic [W:0] cand;

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_i} + (W + 1)'(i);
            if (cand >= (W + 1)'(N)) cand = cand - (W + 1)'(N);
            if (req_i[cand[W-1:0]]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = cand[W-1:0];
            end
        end
    end
endmodule

// File: rtl/i2cm_arb_mch.sv
// Multi-channel trigger arbiter for i2cm: latches triggers, grants one channel at a time,
// snapshots its cfg, launches i2cm and reports per-channel finish/nack toggles.
module i2cm_arb_mch #(
    parameter int    CH_NUM   = 4,
    parameter int    CH_WID   = $clog2(CH_NUM),
    parameter int    NUM_WID  = 5,
    parameter string PRI_MODE = "RR",
    parameter int    CFG_W    = 28
) (
    input  logic                    i2cm_clk,
    input  logic                    i2cm_rst,
    input  logic [CH_NUM-1:0]       i_trg,
    input  logic [CH_NUM*CFG_W-1:0] r_cfg,
    input  logic                    i_i2cm_finish_pulse,
    input  logic                    i_i2cm_wdata_nack,
    output logic                    o_abr_trg,
    output logic                    o_abr_nack,
    output logic                    o_abr_type,
    output logic                    o_abr_stb,
    output logic                    o_abr_seq,
    output logic [NUM_WID-1:0]      o_abr_num,
    output logic [7:0]              o_abr_dev_id,
    output logic [7:0]              o_abr_addr,
    output logic [CH_WID-1:0]       o_abr_ch,
    output logic                    o_abr_busy,
    output logic [CH_NUM-1:0]       o_finish_tgl,
    output logic [CH_NUM-1:0]       o_nack_ntfy_tgl,
    output logic [CH_NUM-1:0]       o_trg_drop_pls
);
    import i2cm_arb_pkg::*;

    localparam bit FIXED_PRI = (PRI_MODE == "FIXED");

    arb_state_e          state_q;
    logic [CH_NUM-1:0]   pend_q, pend_d, drop_q, drop_d, clr;
    logic [CH_NUM-1:0]   ftgl_q, ntgl_q;
    logic [CH_WID-1:0]   ptr_q, pick_ptr, gnt_idx, ch_q;
    logic                gnt_vld, grant, trg_q, busy_q, nack_q;
    logic [CFG_W-1:0]    win_cfg, snap_q;
    logic                win_num_zero, snap_num_zero, cfg_unused;

    assign pick_ptr = FIXED_PRI ? '0 : ptr_q;

    i2cm_rr_pick #(.N(CH_NUM), .W(CH_WID)) u_pick (
        .req_i     (pend_q),
        .ptr_i     (pick_ptr),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        win_cfg = '0;
        for (int k = 0; k < CH_NUM; k++)
            if (gnt_idx == CH_WID'(k)) win_cfg = r_cfg[k*CFG_W +: CFG_W];
    end

    assign grant         = (state_q == IDLE) && gnt_vld;
    assign win_num_zero  = ~|win_cfg[CFG_NUM_LSB +: NUM_WID];
    assign snap_num_zero = ~|snap_q[CFG_NUM_LSB +: NUM_WID];
    assign cfg_unused    = ^win_cfg[CFG_NUM_LSB +: 8];

    // A same-edge trigger on the winner re-pends it: set beats the grant clear.
    always_comb begin
        clr = '0;
        if (grant) clr[gnt_idx] = 1'b1;
        pend_d = (pend_q & ~clr) | i_trg;
        drop_d = i_trg & pend_q & ~clr;
    end

    always_ff @(posedge i2cm_clk or posedge i2cm_rst) begin
        if (i2cm_rst) begin
            pend_q <= '0;
            drop_q <= '0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge i2cm_clk or posedge i2cm_rst) begin
        if (i2cm_rst) begin
            state_q <= IDLE;
            trg_q   <= 1'b0;
            busy_q  <= 1'b0;
            nack_q  <= 1'b0;
            ch_q    <= '0;
            snap_q  <= '0;
            ptr_q   <= '0;
            ftgl_q  <= '0;
            ntgl_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_vld) begin
                    ch_q    <= gnt_idx;
                    snap_q  <= win_cfg;
                    busy_q  <= 1'b1;
                    nack_q  <= 1'b0;
                    trg_q   <= ~win_num_zero;
                    state_q <= LAUNCH;
                end
                // A zero-length transfer never reaches i2cm and completes without nack.
                LAUNCH: begin
                    trg_q   <= 1'b0;
                    state_q <= snap_num_zero ? DONE : BUSY;
                end
                BUSY: if (i_i2cm_finish_pulse) begin
                    nack_q  <= i_i2cm_wdata_nack;
                    state_q <= DONE;
                end
                DONE: begin
                    ftgl_q[ch_q] <= ~ftgl_q[ch_q];
                    if (nack_q) ntgl_q[ch_q] <= ~ntgl_q[ch_q];
                    ptr_q   <= (ch_q == CH_WID'(CH_NUM - 1)) ? '0 : ch_q + 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_abr_trg       = trg_q;
    assign o_abr_busy      = busy_q;
    assign o_abr_ch        = ch_q;
    assign o_abr_nack      = snap_q[CFG_NACK_BIT];
    assign o_abr_type      = snap_q[CFG_TYPE_BIT];
    assign o_abr_stb       = snap_q[CFG_STB_BIT];
    assign o_abr_seq       = snap_q[CFG_SEQ_BIT];
    assign o_abr_num       = snap_q[CFG_NUM_LSB +: NUM_WID];
    assign o_abr_dev_id    = snap_q[CFG_DEV_LSB +: 8];
    assign o_abr_addr      = snap_q[CFG_ADDR_LSB +: 8];
    assign o_finish_tgl    = ftgl_q;
    assign o_nack_ntfy_tgl = ntgl_q;
    assign o_trg_drop_pls  = drop_q;
endmodule

// File: tb/tb_i2cm_arb_mch.sv
// Bench for i2cm_arb_mch: a round-robin and a fixed-priority instance share stimulus and
// are each checked every cycle against a transfer-level model, plus directed scenarios.
module tb_i2cm_arb_mch;
    localparam int N  = 4;
    localparam int CW = 28;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    trg = '0;
    logic [N*CW-1:0] cfg = '0;
    logic            fin = 1'b0;
    logic            nk  = 1'b0;
    bit              chk_en = 1'b0;
    int              tests = 0;
    int              fails = 0;

    always #5 clk = ~clk;

    logic [1:0] a_trg, a_nack, a_type, a_stb, a_seq, a_busy;
    logic [4:0] a_num [2];
    logic [7:0] a_dev [2];
    logic [7:0] a_addr[2];
    logic [1:0] a_ch  [2];
    logic [3:0] a_ft  [2];
    logic [3:0] a_nt  [2];
    logic [3:0] a_dp  [2];

    i2cm_arb_mch #(.CH_NUM(N), .NUM_WID(5), .PRI_MODE("RR")) u_rr (
        .i2cm_clk(clk), .i2cm_rst(rst), .i_trg(trg), .r_cfg(cfg),
        .i_i2cm_finish_pulse(fin), .i_i2cm_wdata_nack(nk),
        .o_abr_trg(a_trg[0]), .o_abr_nack(a_nack[0]), .o_abr_type(a_type[0]),
        .o_abr_stb(a_stb[0]), .o_abr_seq(a_seq[0]), .o_abr_num(a_num[0]),
        .o_abr_dev_id(a_dev[0]), .o_abr_addr(a_addr[0]), .o_abr_ch(a_ch[0]),
        .o_abr_busy(a_busy[0]), .o_finish_tgl(a_ft[0]), .o_nack_ntfy_tgl(a_nt[0]),
        .o_trg_drop_pls(a_dp[0]));

    i2cm_arb_mch #(.CH_NUM(N), .NUM_WID(5), .PRI_MODE("FIXED")) u_fx (
        .i2cm_clk(clk), .i2cm_rst(rst), .i_trg(trg), .r_cfg(cfg),
        .i_i2cm_finish_pulse(fin), .i_i2cm_wdata_nack(nk),
        .o_abr_trg(a_trg[1]), .o_abr_nack(a_nack[1]), .o_abr_type(a_type[1]),
        .o_abr_stb(a_stb[1]), .o_abr_seq(a_seq[1]), .o_abr_num(a_num[1]),
        .o_abr_dev_id(a_dev[1]), .o_abr_addr(a_addr[1]), .o_abr_ch(a_ch[1]),
        .o_abr_busy(a_busy[1]), .o_finish_tgl(a_ft[1]), .o_nack_ntfy_tgl(a_nt[1]),
        .o_trg_drop_pls(a_dp[1]));

    // Transfer-level model: one in-flight transfer per instance, tracked by phase flags.
    logic [3:0]  m_pend[2];
    logic [1:0]  m_ptr [2];
    logic [1:0]  m_ch  [2];
    bit          m_act[2], m_launch[2], m_done[2], m_nk[2], e_trg[2];
    logic [27:0] m_snap[2];
    logic [3:0]  e_ft[2], e_nt[2], e_dp[2];

    task automatic model_step(input int d);
        logic [3:0] clr;
        logic [1:0] pb, kk, g;
        bit found;
        clr = '0; found = 1'b0; g = '0;
        if (rst) begin
            m_pend[d] = '0; m_ptr[d] = '0; m_ch[d] = '0; m_snap[d] = '0;
            m_act[d] = 0; m_launch[d] = 0; m_done[d] = 0; m_nk[d] = 0; e_trg[d] = 0;
            e_ft[d] = '0; e_nt[d] = '0; e_dp[d] = '0;
            return;
        end
        e_trg[d] = 1'b0;
        if (m_act[d]) begin
            if (m_done[d]) begin
                e_ft[d][m_ch[d]] = ~e_ft[d][m_ch[d]];
                if (m_nk[d]) e_nt[d][m_ch[d]] = ~e_nt[d][m_ch[d]];
                m_ptr[d] = m_ch[d] + 2'd1;
                m_act[d] = 1'b0;
            end else if (m_launch[d]) begin
                m_launch[d] = 1'b0;
                if (m_snap[d][20:16] == 5'd0) begin m_done[d] = 1'b1; m_nk[d] = 1'b0; end
            end else if (fin) begin
                m_done[d] = 1'b1; m_nk[d] = nk;
            end
        end else if (m_pend[d] != 4'd0) begin
            pb = (d == 0) ? m_ptr[d] : 2'd0;
            for (int i = 0; i < N; i++) begin
                kk = pb + 2'(i);
                if (!found && m_pend[d][kk]) begin found = 1'b1; g = kk; end
            end
            clr[g] = 1'b1;
            m_act[d] = 1'b1; m_launch[d] = 1'b1; m_done[d] = 1'b0; m_nk[d] = 1'b0;
            m_ch[d] = g;
            m_snap[d] = cfg[int'(g)*CW +: CW];
            e_trg[d] = (m_snap[d][20:16] != 5'd0);
        end
        e_dp[d] = trg & m_pend[d] & ~clr;
        m_pend[d] = (m_pend[d] & ~clr) | trg;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    function automatic logic [40:0] exp_vec(input int d);
        return {e_trg[d], m_act[d], m_ch[d], m_snap[d][27:24], m_snap[d][20:16],
                m_snap[d][15:8], m_snap[d][7:0], e_ft[d], e_nt[d], e_dp[d]};
    endfunction

    function automatic logic [40:0] act_vec(input int d);
        return {a_trg[d], a_busy[d], a_ch[d], a_nack[d], a_type[d], a_stb[d], a_seq[d],
                a_num[d], a_dev[d], a_addr[d], a_ft[d], a_nt[d], a_dp[d]};
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (act_vec(d) !== exp_vec(d)) begin
                    fails++;
                    $display("FAIL model_cmp dut%0d t=%0t got=%h want=%h", d, $time, act_vec(d), exp_vec(d));
                end
            end
        end
    end

    logic [1:0] gq_rr[$];
    logic [1:0] gq_fx[$];
    int drop1 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_trg[0]) gq_rr.push_back(a_ch[0]);
            if (a_trg[1]) gq_fx.push_back(a_ch[1]);
            if (a_dp[0][1]) drop1++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] qpack(input logic [1:0] q[$]);
        logic [63:0] v;
        v = 64'(q.size()) << 32;
        foreach (q[i]) if (i < 8) v[i*4 +: 4] = {2'b00, q[i]};
        return v;
    endfunction

    function automatic int qcnt(input logic [1:0] q[$], input logic [1:0] ch);
        int c = 0;
        foreach (q[i]) if (q[i] == ch) c++;
        return c;
    endfunction

    task automatic set_cfg(input int k, input logic [7:0] num);
        cfg[k*CW +: CW] = {4'b1010, num, 8'h50 + 8'(k), 8'(k * 16 + 3)};
    endtask

    // Inputs change 1 time unit after the falling edge and are held across one rising edge.
    task automatic tick(input logic [3:0] t, input logic f, input logic n);
        trg = t; fin = f; nk = n;
        @(negedge clk); #1;
        trg = '0; fin = 1'b0; nk = 1'b0;
    endtask

    logic [3:0] ft0, nt0, ft1, nt1;

    initial begin
        for (int k = 0; k < N; k++) set_cfg(k, 8'h03);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rr", 64'(act_vec(0)), 64'd0);
        chk("reset_fx", 64'(act_vec(1)), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // All four requested at once: served in index order, each finish toggles once.
        gq_rr.delete(); gq_fx.delete();
        ft0 = a_ft[0]; nt0 = a_nt[0];
        tick(4'b1111, 1'b0, 1'b0);
        repeat (30) tick(4'b0000, 1'b1, 1'b0);
        chk("rr_order", qpack(gq_rr), 64'h4_0000_3210);
        chk("fx_order", qpack(gq_fx), 64'h4_0000_3210);
        chk("all_fin_tgl", 64'(a_ft[0] ^ ft0), 64'hf);
        chk("all_nack_tgl", 64'(a_nt[0] ^ nt0), 64'h0);

        // Channel 2 finishes with nack.
        ft0 = a_ft[0]; nt0 = a_nt[0]; ft1 = a_ft[1]; nt1 = a_nt[1];
        tick(4'b0100, 1'b0, 1'b0);
        repeat (4) tick(4'b0000, 1'b0, 1'b0);
        chk("ch2_busy", 64'({a_busy[0], a_ch[0]}), 64'h6);
        tick(4'b0000, 1'b1, 1'b1);
        repeat (3) tick(4'b0000, 1'b0, 1'b0);
        chk("ch2_fin_rr", 64'(a_ft[0] ^ ft0), 64'h4);
        chk("ch2_nack_rr", 64'(a_nt[0] ^ nt0), 64'h4);
        chk("ch2_fin_fx", 64'(a_ft[1] ^ ft1), 64'h4);
        chk("ch2_nack_fx", 64'(a_nt[1] ^ nt1), 64'h4);

        // Second trigger on an already pending ch1 merges into one request.
        gq_rr.delete(); drop1 = 0;
        tick(4'b0001, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        repeat (25) tick(4'b0000, 1'b1, 1'b0);
        chk("ch1_drop_cnt", 64'(drop1), 64'd1);
        chk("ch1_grant_cnt", 64'(qcnt(gq_rr, 2'd1)), 64'd1);
        chk("ch0_grant_cnt", 64'(qcnt(gq_rr, 2'd0)), 64'd1);

        // Count 0x20 truncates to zero: no launch pulse, completion 3 cycles after pend.
        set_cfg(0, 8'h20);
        ft0 = a_ft[0]; gq_rr.delete();
        tick(4'b0001, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        chk("zero_launch", 64'({a_trg[0], a_busy[0]}), 64'h1);
        tick(4'b0000, 1'b1, 1'b0);
        chk("zero_done_hold", 64'(a_ft[0] ^ ft0), 64'h0);
        tick(4'b0000, 1'b1, 1'b0);
        chk("zero_fin_tgl", 64'(a_ft[0] ^ ft0), 64'h1);
        chk("zero_no_trg", 64'(gq_rr.size()), 64'd0);
        set_cfg(0, 8'h03);
        repeat (3) tick(4'b0000, 1'b0, 1'b0);

        // Fixed priority: ch1 beats a repeatedly re-triggered ch3.
        gq_fx.delete();
        tick(4'b1010, 1'b0, 1'b0);
        repeat (20) tick(4'b1000, 1'b1, 1'b0);
        chk("fx_first_ch1", (gq_fx.size() > 0) ? 64'(gq_fx[0]) : 64'hff, 64'd1);
        chk("fx_ch1_once", 64'(qcnt(gq_fx, 2'd1)), 64'd1);
        repeat (12) tick(4'b0000, 1'b1, 1'b0);

        // Reset while ch1 is in flight.
        tick(4'b0010, 1'b0, 1'b0);
        repeat (3) tick(4'b0000, 1'b0, 1'b0);
        chk("pre_rst_busy", 64'({a_busy[0], a_ch[0]}), 64'h5);
        rst = 1'b1;
        #1;
        chk("rst_async_rr", 64'(act_vec(0)), 64'd0);
        @(negedge clk); #1;
        chk("rst_hold_fx", 64'(act_vec(1)), 64'd0);
        rst = 1'b0;
        gq_rr.delete();
        tick(4'b0011, 1'b0, 1'b0);
        repeat (12) tick(4'b0000, 1'b1, 1'b0);
        chk("restart_first_ch0", (gq_rr.size() > 0) ? 64'(gq_rr[0]) : 64'hff, 64'd0);

        // Random traffic against the model, with cfg churn and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0)
                cfg[$urandom_range(0, 3)*CW +: CW] = {4'($urandom),
                    ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'he0) : 8'($urandom),
                    8'($urandom), 8'($urandom)};
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                @(negedge clk); #1;
                rst = 1'b0;
            end
            tick(4'($urandom) & 4'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
